// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and load/store requests onto one single-port memory, one transaction in flight.
// Grant -> mem_req_valid next cycle; response registered one cycle after mem_rsp_valid; requesters stall via *_req_ready.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    if_req_valid,
  output logic                    if_req_ready,
  input  logic [ADDR_WIDTH-1:0]   if_addr,
  output logic                    if_rsp_valid,
  output logic [DATA_WIDTH-1:0]   if_rsp_data,
  output logic                    if_rsp_err,
  input  logic                    d_req_valid,
  output logic                    d_req_ready,
  input  logic                    d_we,
  input  logic [ADDR_WIDTH-1:0]   d_addr,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  input  logic [DATA_WIDTH/8-1:0] d_wstrb,
  output logic                    d_rsp_valid,
  output logic [DATA_WIDTH-1:0]   d_rsp_data,
  output logic                    d_rsp_err,
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_wstrb,
  input  logic                    mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]   mem_rsp_data
);
  localparam int SW = DATA_WIDTH / 8;
  localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TLAST = (TIMEOUT_CYCLES > 0) ? TW'(TIMEOUT_CYCLES - 1) : '0;
  localparam bit TO_EN = (TIMEOUT_CYCLES > 0);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t                  r_state;
  logic                    r_prio_d;
  logic                    r_owner_d;
  logic [TW-1:0]           r_timer;
  logic                    r_mem_req_valid;
  logic                    r_mem_we;
  logic [ADDR_WIDTH-1:0]   r_mem_addr;
  logic [DATA_WIDTH-1:0]   r_mem_wdata;
  logic [SW-1:0]           r_mem_wstrb;
  logic                    r_if_rsp_valid, r_if_rsp_err;
  logic                    r_d_rsp_valid, r_d_rsp_err;
  logic [DATA_WIDTH-1:0]   r_if_rsp_data, r_d_rsp_data;

  logic w_idle, w_grant_d, w_grant_if, w_both, w_timeout;

  // Ready is gated by reset so nothing can be accepted and then dropped while reset is held.
  assign w_idle     = (r_state == S_IDLE) && !reset;
  assign w_both     = if_req_valid && d_req_valid;
  assign w_grant_d  = w_idle && d_req_valid && (!if_req_valid || r_prio_d);
  assign w_grant_if = w_idle && if_req_valid && (!d_req_valid || !r_prio_d);
  assign w_timeout  = TO_EN && (r_timer == TLAST);

  assign if_req_ready  = w_grant_if;
  assign d_req_ready   = w_grant_d;
  assign mem_req_valid = r_mem_req_valid;
  assign mem_we        = r_mem_we;
  assign mem_addr      = r_mem_addr;
  assign mem_wdata     = r_mem_wdata;
  assign mem_wstrb     = r_mem_wstrb;
  assign if_rsp_valid  = r_if_rsp_valid;
  assign if_rsp_err    = r_if_rsp_err;
  assign if_rsp_data   = r_if_rsp_data;
  assign d_rsp_valid   = r_d_rsp_valid;
  assign d_rsp_err     = r_d_rsp_err;
  assign d_rsp_data    = r_d_rsp_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= S_IDLE;
      r_prio_d        <= 1'b1;
      r_owner_d       <= 1'b0;
      r_timer         <= '0;
      r_mem_req_valid <= 1'b0;
      r_mem_we        <= 1'b0;
      r_mem_addr      <= '0;
      r_mem_wdata     <= '0;
      r_mem_wstrb     <= '0;
      r_if_rsp_valid  <= 1'b0;
      r_if_rsp_err    <= 1'b0;
      r_if_rsp_data   <= '0;
      r_d_rsp_valid   <= 1'b0;
      r_d_rsp_err     <= 1'b0;
      r_d_rsp_data    <= '0;
    end else begin
      // Response outputs are single-cycle pulses; data is zero outside the pulse.
      r_if_rsp_valid <= 1'b0;
      r_if_rsp_err   <= 1'b0;
      r_if_rsp_data  <= '0;
      r_d_rsp_valid  <= 1'b0;
      r_d_rsp_err    <= 1'b0;
      r_d_rsp_data   <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_grant_d || w_grant_if) begin
            r_mem_req_valid <= 1'b1;
            r_mem_we        <= w_grant_d && d_we;
            r_mem_addr      <= w_grant_d ? d_addr : if_addr;
            r_mem_wdata     <= w_grant_d ? d_wdata : '0;
            r_mem_wstrb     <= w_grant_d ? d_wstrb : '0;
            r_owner_d       <= w_grant_d;
            if (w_both) r_prio_d <= w_grant_if;
            r_state         <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (mem_req_ready) begin
            r_mem_req_valid <= 1'b0;
            r_timer         <= '0;
            r_state         <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_rsp_valid || w_timeout) begin
            if (r_owner_d) begin
              r_d_rsp_valid <= 1'b1;
              r_d_rsp_err   <= !mem_rsp_valid;
              r_d_rsp_data  <= mem_rsp_valid ? mem_rsp_data : '0;
            end else begin
              r_if_rsp_valid <= 1'b1;
              r_if_rsp_err   <= !mem_rsp_valid;
              r_if_rsp_data  <= mem_rsp_valid ? mem_rsp_data : '0;
            end
            r_state <= S_IDLE;
          end else if (r_timer != {TW{1'b1}}) begin
            r_timer <= r_timer + TW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized checks of mem_port_arbiter against a transaction-level model of arbitration and memory.
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        if_req_valid, if_req_ready, if_rsp_valid, if_rsp_err;
  logic [31:0] if_addr, if_rsp_data;
  logic        d_req_valid, d_req_ready, d_we, d_rsp_valid, d_rsp_err;
  logic [31:0] d_addr, d_wdata, d_rsp_data;
  logic [3:0]  d_wstrb, mem_wstrb;
  logic        mem_req_valid, mem_req_ready, mem_we, mem_rsp_valid;
  logic [31:0] mem_addr, mem_wdata, mem_rsp_data;

  int          vectors = 0;
  int          miscompares = 0;
  bit          prio_d;
  logic [31:0] mem_model [16];

  mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data), .if_rsp_err(if_rsp_err),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_we(d_we), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data), .d_rsp_err(d_rsp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_no_rsp(input string tag);
    chk({tag, "_if_rsp_valid"}, {31'd0, if_rsp_valid}, 32'd0);
    chk({tag, "_d_rsp_valid"}, {31'd0, d_rsp_valid}, 32'd0);
  endtask

  task automatic new_if(input logic [31:0] a);
    if_req_valid = 1'b1;
    if_addr      = a;
  endtask

  task automatic new_d(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st);
    d_req_valid = 1'b1;
    d_we        = we;
    d_addr      = a;
    d_wdata     = wd;
    d_wstrb     = st;
  endtask

  // Round-robin rule: a tie goes to the prioritised side and hands priority to the loser.
  task automatic pick(output bit wd);
    if (if_req_valid && d_req_valid) begin
      wd     = prio_d;
      prio_d = !wd;
    end else begin
      wd = d_req_valid;
    end
  endtask

  // Runs one granted transaction from the grant cycle; rspdly < 0 means the memory never answers.
  task automatic txn(input bit wd, input int rdly, input int rspdly, input bit stray);
    logic [31:0] a, wdat, rdata;
    logic        we;
    logic [3:0]  st;
    #1;
    chk("grant_d_ready", {31'd0, d_req_ready}, {31'd0, wd});
    chk("grant_if_ready", {31'd0, if_req_ready}, {31'd0, !wd});
    we   = wd ? d_we : 1'b0;
    a    = wd ? d_addr : if_addr;
    wdat = wd ? d_wdata : 32'd0;
    st   = wd ? d_wstrb : 4'd0;
    tick();
    if (wd) d_req_valid = 1'b0; else if_req_valid = 1'b0;
    for (int k = 0; k <= rdly; k++) begin
      mem_req_ready = (k == rdly);
      mem_rsp_valid = stray && (k == 0) && (rdly > 0);
      mem_rsp_data  = $urandom;
      #1;
      chk("issue_valid", {31'd0, mem_req_valid}, 32'd1);
      chk("issue_addr", mem_addr, a);
      chk("issue_we", {31'd0, mem_we}, {31'd0, we});
      chk("issue_wdata", mem_wdata, wdat);
      chk("issue_wstrb", {28'd0, mem_wstrb}, {28'd0, st});
      chk("issue_ready", {31'd0, d_req_ready | if_req_ready}, 32'd0);
      chk_no_rsp("issue");
      tick();
      mem_rsp_valid = 1'b0;
    end
    mem_req_ready = 1'b0;
    chk("wait_mem_req_valid", {31'd0, mem_req_valid}, 32'd0);
    if (rspdly < 0) begin
      for (int k = 0; k < 8; k++) begin
        chk_no_rsp("pre_timeout");
        tick();
      end
      chk("to_d_valid", {31'd0, d_rsp_valid}, {31'd0, wd});
      chk("to_if_valid", {31'd0, if_rsp_valid}, {31'd0, !wd});
      chk("to_err", {31'd0, wd ? d_rsp_err : if_rsp_err}, 32'd1);
      chk("to_data", wd ? d_rsp_data : if_rsp_data, 32'd0);
      return;
    end
    rdata = we ? $urandom : mem_model[a[5:2]];
    for (int k = 0; k <= rspdly; k++) begin
      chk_no_rsp("wait");
      chk("wait_ready", {31'd0, d_req_ready | if_req_ready}, 32'd0);
      mem_rsp_valid = (k == rspdly);
      mem_rsp_data  = (k == rspdly) ? rdata : $urandom;
      tick();
    end
    mem_rsp_valid = 1'b0;
    if (we)
      for (int b = 0; b < 4; b++)
        if (st[b]) mem_model[a[5:2]][8*b +: 8] = wdat[8*b +: 8];
    chk("rsp_d_valid", {31'd0, d_rsp_valid}, {31'd0, wd});
    chk("rsp_if_valid", {31'd0, if_rsp_valid}, {31'd0, !wd});
    chk("rsp_err", {31'd0, d_rsp_err | if_rsp_err}, 32'd0);
    if (!we) chk("rsp_data", wd ? d_rsp_data : if_rsp_data, rdata);
    chk("rsp_other_data", wd ? if_rsp_data : d_rsp_data, 32'd0);
  endtask

  initial begin
    bit wd;
    for (int i = 0; i < 16; i++) mem_model[i] = $urandom;
    reset = 1'b1; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = 32'd0;
    if_req_valid = 1'b0; if_addr = 32'd0;
    d_req_valid = 1'b0; d_we = 1'b0; d_addr = 32'd0; d_wdata = 32'd0; d_wstrb = 4'd0;
    tick(); tick();
    // Reset state, with both requesters already pending.
    new_if(32'h8); new_d(1'b0, 32'h24, 32'd0, 4'd0);
    #1;
    chk("rst_if_ready", {31'd0, if_req_ready}, 32'd0);
    chk("rst_d_ready", {31'd0, d_req_ready}, 32'd0);
    chk("rst_mem_req_valid", {31'd0, mem_req_valid}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk_no_rsp("rst");
    tick();
    reset = 1'b0;
    prio_d = 1'b1;

    // Both pending from reset exit: D, IF, D, IF.
    for (int i = 0; i < 4; i++) begin
      pick(wd);
      chk("alt_order", {31'd0, wd}, (i % 2 == 0) ? 32'd1 : 32'd0);
      txn(wd, 0, 0, 1'b0);
      if (wd) new_d(1'b0, 32'($urandom_range(0, 15)) << 2, 32'd0, 4'd0);
      else    new_if(32'($urandom_range(0, 15)) << 2);
    end
    if_req_valid = 1'b0; d_req_valid = 1'b0;
    tick();

    // Fetch only.
    mem_model[4] = 32'hDEADBEEF;
    new_if(32'h10);
    pick(wd);
    txn(wd, 0, 0, 1'b0);
    chk("fetch_data", if_rsp_data, 32'hDEADBEEF);
    tick();
    chk_no_rsp("fetch_after");

    // Store with memory stalling for 5 cycles.
    new_d(1'b1, 32'h40, 32'h12345678, 4'b0011);
    pick(wd);
    txn(wd, 5, 1, 1'b0);

    // Timeout, then a late response that must be ignored.
    new_d(1'b0, 32'h4, 32'd0, 4'd0);
    pick(wd);
    txn(wd, 0, -1, 1'b0);
    tick(); chk_no_rsp("late_a");
    tick(); chk_no_rsp("late_b");
    tick();
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'hCAFEF00D;
    tick();
    mem_rsp_valid = 1'b0;
    chk_no_rsp("late_rsp");
    chk("late_mem_req_valid", {31'd0, mem_req_valid}, 32'd0);

    // Stray response in IDLE, then one during ISSUE.
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h55AA55AA;
    tick();
    mem_rsp_valid = 1'b0;
    chk_no_rsp("stray_idle");
    chk("stray_idle_mem_req", {31'd0, mem_req_valid}, 32'd0);
    new_if(32'h20);
    pick(wd);
    txn(wd, 2, 0, 1'b1);

    // Reset while waiting on memory abandons the transaction.
    new_d(1'b1, 32'h30, 32'hA5A5A5A5, 4'hF);
    #1; chk("mid_grant", {31'd0, d_req_ready}, 32'd1);
    tick(); d_req_valid = 1'b0; mem_req_ready = 1'b1;
    tick(); mem_req_ready = 1'b0;
    tick(); reset = 1'b1;
    tick();
    chk("mid_mem_req_valid", {31'd0, mem_req_valid}, 32'd0);
    chk("mid_mem_addr", mem_addr, 32'd0);
    chk("mid_mem_wdata", mem_wdata, 32'd0);
    chk("mid_mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
    chk("mid_mem_we", {31'd0, mem_we}, 32'd0);
    chk_no_rsp("mid_rst");
    reset = 1'b0;
    prio_d = 1'b1;
    tick();
    chk_no_rsp("mid_after");
    new_if(32'h2C);
    pick(wd);
    txn(wd, 0, 0, 1'b0);
    new_if(32'h14); new_d(1'b0, 32'h18, 32'd0, 4'd0);
    pick(wd);
    chk("post_rst_prio", {31'd0, wd}, 32'd1);
    txn(wd, 0, 0, 1'b0);

    // Randomized traffic against the model.
    for (int it = 0; it < 40; it++) begin
      if (!if_req_valid && $urandom_range(0, 1) == 1) new_if(32'($urandom_range(0, 15)) << 2);
      if (!d_req_valid && $urandom_range(0, 1) == 1)
        new_d(1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)) << 2, $urandom, 4'($urandom_range(0, 15)));
      if (!if_req_valid && !d_req_valid)
        new_d(1'b0, 32'($urandom_range(0, 15)) << 2, 32'd0, 4'd0);
      pick(wd);
      txn(wd, $urandom_range(0, 3), $urandom_range(0, 6), $urandom_range(0, 3) == 0);
    end
    if_req_valid = 1'b0; d_req_valid = 1'b0;
    tick();
    chk_no_rsp("final");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
